// File: rtl/sistema_ram_filler_if.sv
// Avalon-MM bus between the RAM filler (master) and the RAM s2 port (slave).
// Fixed read latency of 1, no waitrequest: a read issued with chipselect=1,
// write=0 in cycle k returns avm_readdata in cycle k+1.
interface sistema_ram_filler_if #(parameter int AW = 12);
   logic [AW-1:0] avm_address;
   logic [3:0]    avm_byteenable;
   logic          avm_chipselect;
   logic          avm_write;
   logic [31:0]   avm_writedata;
   logic [31:0]   avm_readdata;

   modport master (
      output avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
      input  avm_readdata
   );
   modport slave (
      input  avm_address, avm_byteenable, avm_chipselect, avm_write, avm_writedata,
      output avm_readdata
   );
endinterface

// File: rtl/sistema_ram_filler.sv
// Fills a RAM region with a constant or incrementing pattern, optionally reads
// it back and counts mismatches. All bus outputs are registered.
module sistema_ram_filler #(
   parameter int DEPTH = 3750,
   parameter int AW    = 12
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          abort,
   input  logic [AW-1:0] base,
   input  logic [12:0]   count,
   input  logic [31:0]   pattern,
   input  logic          incr,
   input  logic          verify,
   output logic          busy,
   output logic          done,
   output logic          range_err,
   output logic          aborted,
   output logic [12:0]   err_count,
   output logic [AW-1:0] first_err_addr,
   output logic [2:0]    dbg_state,
   sistema_ram_filler_if.master avm
);

   typedef enum logic [2:0] {IDLE, FILL, VERIFY, DRAIN, DONE} state_t;

   state_t        state, state_nx;
   logic [12:0]   idx, idx_nx;
   logic [AW-1:0] base_q;
   logic [12:0]   count_q;
   logic [31:0]   pattern_q;
   logic          incr_q, verify_q;
   logic          cs_q, cs_nx, wr_q, wr_nx;
   logic [AW-1:0] addr_q, addr_nx;
   logic [31:0]   data_q, data_nx;
   logic          cmp_valid;
   logic [31:0]   exp_data;
   logic [AW-1:0] exp_addr;
   logic          latch, clr_err, clr_flags, set_range, set_abort;
   logic [12:0]   span;
   logic          mismatch;

   assign span     = {1'b0, base} + count;
   assign mismatch = cmp_valid && (avm.avm_readdata != exp_data);

   always_comb begin
      state_nx  = state;
      idx_nx    = idx;
      cs_nx     = 1'b0;
      wr_nx     = 1'b0;
      addr_nx   = '0;
      data_nx   = '0;
      latch     = 1'b0;
      clr_err   = 1'b0;
      clr_flags = 1'b0;
      set_range = 1'b0;
      set_abort = 1'b0;
      case (state)
         IDLE: if (start) begin
            latch     = 1'b1;
            clr_flags = 1'b1;
            if (count == 13'd0) begin
               state_nx = DONE;
            end else if (span > 13'(DEPTH)) begin
               state_nx  = DONE;
               set_range = 1'b1;
            end else begin
               state_nx = FILL;
               clr_err  = 1'b1;
               idx_nx   = '0;
               cs_nx    = 1'b1;
               wr_nx    = 1'b1;
               addr_nx  = base;
               data_nx  = pattern;
            end
         end
         FILL: begin
            if (abort) begin
               state_nx  = DONE;
               set_abort = 1'b1;
            end else if (idx == count_q - 13'd1) begin
               if (verify_q) begin
                  // reads start back at word 0 with no idle gap
                  state_nx = VERIFY;
                  idx_nx   = '0;
                  cs_nx    = 1'b1;
                  addr_nx  = base_q;
               end else begin
                  state_nx = DONE;
               end
            end else begin
               idx_nx  = idx + 13'd1;
               cs_nx   = 1'b1;
               wr_nx   = 1'b1;
               addr_nx = base_q + AW'(idx_nx);
               data_nx = pattern_q + (incr_q ? {19'd0, idx_nx} : 32'd0);
            end
         end
         VERIFY: begin
            if (abort) begin
               state_nx  = DRAIN;
               set_abort = 1'b1;
            end else if (idx == count_q - 13'd1) begin
               state_nx = DRAIN;
            end else begin
               idx_nx  = idx + 13'd1;
               cs_nx   = 1'b1;
               addr_nx = base_q + AW'(idx_nx);
            end
         end
         DRAIN: begin
            state_nx = DONE;
            if (abort) set_abort = 1'b1;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         idx            <= '0;
         base_q         <= '0;
         count_q        <= '0;
         pattern_q      <= '0;
         incr_q         <= 1'b0;
         verify_q       <= 1'b0;
         cs_q           <= 1'b0;
         wr_q           <= 1'b0;
         addr_q         <= '0;
         data_q         <= '0;
         cmp_valid      <= 1'b0;
         exp_data       <= '0;
         exp_addr       <= '0;
         range_err      <= 1'b0;
         aborted        <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         state  <= state_nx;
         idx    <= idx_nx;
         cs_q   <= cs_nx;
         wr_q   <= wr_nx;
         addr_q <= addr_nx;
         data_q <= data_nx;
         if (latch) begin
            base_q    <= base;
            count_q   <= count;
            pattern_q <= pattern;
            incr_q    <= incr;
            verify_q  <= verify;
         end
         // expected word for the read on the bus now; compared next cycle
         cmp_valid <= cs_q & ~wr_q;
         exp_addr  <= addr_q;
         exp_data  <= pattern_q + (incr_q ? {19'd0, idx} : 32'd0);
         if (clr_flags) begin
            range_err <= 1'b0;
            aborted   <= 1'b0;
         end
         if (set_range) range_err <= 1'b1;
         if (set_abort) aborted   <= 1'b1;
         if (clr_err) begin
            err_count      <= '0;
            first_err_addr <= '0;
         end else if (mismatch) begin
            if (err_count == 13'd0)    first_err_addr <= exp_addr;
            if (err_count != 13'h1FFF) err_count      <= err_count + 13'd1;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

   assign avm.avm_address    = addr_q;
   assign avm.avm_byteenable = 4'hF;
   assign avm.avm_chipselect = cs_q;
   assign avm.avm_write      = wr_q;
   assign avm.avm_writedata  = data_q;

endmodule

// File: tb/tb_sistema_ram_filler.sv
// Directed bench for sistema_ram_filler: RAM model on the bus, scoreboard queues
// for expected writes and done reports, monitor comparing on the falling edge.
module tb_sistema_ram_filler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [11:0] base = '0;
   logic [12:0] count = '0;
   logic [31:0] pattern = '0;
   logic        incr = 1'b0;
   logic        verify = 1'b0;
   logic        busy, done, range_err, aborted;
   logic [12:0] err_count;
   logic [11:0] first_err_addr;
   logic [2:0]  dbg_state;

   sistema_ram_filler_if #(.AW(12)) bus ();

   sistema_ram_filler #(.DEPTH(3750), .AW(12)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .base(base), .count(count), .pattern(pattern), .incr(incr), .verify(verify),
      .busy(busy), .done(done), .range_err(range_err), .aborted(aborted),
      .err_count(err_count), .first_err_addr(first_err_addr), .dbg_state(dbg_state),
      .avm(bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int since_start = 0;
   int rd_cnt = 0;
   int done_cnt = 0;
   logic corrupt_en = 1'b0;

   logic [43:0] wr_q[$];    // {address, data}
   logic [42:0] done_q[$];  // {cycle, range_err, aborted, err_count, first_err_addr}

   // RAM model: 1-cycle read latency, optional forced-zero words
   logic [31:0] mem [0:4095];
   always @(posedge clk) begin
      if (bus.avm_chipselect && bus.avm_write)
         mem[bus.avm_address] <= bus.avm_writedata;
      if (bus.avm_chipselect && !bus.avm_write) begin
         if (corrupt_en && (bus.avm_address == 12'h015 || bus.avm_address == 12'h01A))
            bus.avm_readdata <= 32'd0;
         else
            bus.avm_readdata <= mem[bus.avm_address];
      end
   end

   // cycle number relative to the edge that sampled start (that edge = 0)
   always @(posedge clk) begin
      if (start) since_start <= 1;
      else       since_start <= since_start + 1;
   end

   // monitor
   always @(negedge clk) begin
      logic [43:0] w;
      logic [42:0] d, got;
      if (reset_n) begin
         if (bus.avm_chipselect && bus.avm_write) begin
            total++;
            if (wr_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_write addr=%h data=%h", bus.avm_address, bus.avm_writedata);
            end else begin
               w = wr_q.pop_front();
               if ({bus.avm_address, bus.avm_writedata} !== w) begin
                  bad++;
                  $display("FAIL write got addr=%h data=%h exp addr=%h data=%h",
                           bus.avm_address, bus.avm_writedata, w[43:32], w[31:0]);
               end
            end
         end
         if (bus.avm_chipselect && !bus.avm_write) rd_cnt++;
         if (done) begin
            done_cnt++;
            total++;
            got = {16'(since_start), range_err, aborted, err_count, first_err_addr};
            if (done_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_done got=%h", got);
            end else begin
               d = done_q.pop_front();
               if (got !== d) begin
                  bad++;
                  $display("FAIL done got cyc=%0d rerr=%b ab=%b err=%0d first=%h exp cyc=%0d rerr=%b ab=%b err=%0d first=%h",
                           got[42:27], got[26], got[25], got[24:12], got[11:0],
                           d[42:27], d[26], d[25], d[24:12], d[11:0]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [11:0] b, input logic [12:0] c, input logic [31:0] p,
                        input logic inc, input logic ver);
      @(negedge clk);
      base = b; count = c; pattern = p; incr = inc; verify = ver; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
   endtask

   task automatic run_op(input logic [11:0] b, input logic [12:0] c, input logic [31:0] p,
                         input logic inc, input logic ver, input int n_wr, input int n_rd,
                         input int exp_cyc, input logic exp_rerr, input logic exp_ab,
                         input logic [12:0] exp_err, input logic [11:0] exp_first,
                         input int abort_at, input string name);
      int d0;
      for (int i = 0; i < n_wr; i++)
         wr_q.push_back({b + 12'(i), p + (inc ? 32'(i) : 32'd0)});
      done_q.push_back({16'(exp_cyc), exp_rerr, exp_ab, exp_err, exp_first});
      rd_cnt = 0;
      d0 = done_cnt;
      issue(b, c, p, inc, ver);
      for (int k = 0; k < 400 && done_cnt == d0; k++) begin
         abort = (since_start == abort_at);
         @(negedge clk);
         #1;
      end
      abort = 1'b0;
      total++;
      if (done_cnt == d0) begin
         bad++;
         $display("FAIL %s timeout waiting for done", name);
      end
      @(negedge clk);
      #1;
      check({name, "_busy_low"}, 64'(busy), 64'd0);
      check({name, "_reads"}, 64'(rd_cnt), 64'(n_rd));
      check({name, "_writes_left"}, 64'(wr_q.size()), 64'd0);
   endtask

   initial begin
      int d0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_outputs", {busy, done, range_err, aborted, err_count, first_err_addr,
                              bus.avm_chipselect, bus.avm_write, bus.avm_address},
            {4'b0, 13'd0, 12'd0, 2'b0, 12'd0});
      check("reset_bus_data", {bus.avm_byteenable, bus.avm_writedata}, {4'hF, 32'd0});
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op(12'h010, 13'd16, 32'hA5A50000, 1'b1, 1'b0, 16, 0, 17, 1'b0, 1'b0, 13'd0, 12'h000, -1, "fill_only");
      run_op(12'h010, 13'd16, 32'hA5A50000, 1'b1, 1'b1, 16, 16, 34, 1'b0, 1'b0, 13'd0, 12'h000, -1, "fill_verify");
      corrupt_en = 1'b1;
      run_op(12'h010, 13'd16, 32'hA5A50000, 1'b1, 1'b1, 16, 16, 34, 1'b0, 1'b0, 13'd2, 12'h015, -1, "corrupt");
      corrupt_en = 1'b0;
      run_op(12'h010, 13'd0, 32'h0, 1'b0, 1'b0, 0, 0, 1, 1'b0, 1'b0, 13'd2, 12'h015, -1, "count_zero");
      run_op(12'd3740, 13'd20, 32'h0, 1'b0, 1'b0, 0, 0, 1, 1'b1, 1'b0, 13'd2, 12'h015, -1, "range");
      run_op(12'h100, 13'd100, 32'h11110000, 1'b0, 1'b0, 5, 0, 6, 1'b0, 1'b1, 13'd0, 12'h000, 5, "abort");
      run_op(12'd3734, 13'd16, 32'hDEAD0000, 1'b1, 1'b1, 16, 16, 34, 1'b0, 1'b0, 13'd0, 12'h000, -1, "boundary");
      check("last_word_3749", 64'(mem[12'd3749]), 64'hDEAD000F);

      // reset in the middle of the read-back phase
      for (int i = 0; i < 16; i++) wr_q.push_back({12'h030 + 12'(i), 32'h5A5A0000 + 32'(i)});
      d0 = done_cnt;
      issue(12'h030, 13'd16, 32'h5A5A0000, 1'b1, 1'b1);
      for (int k = 0; k < 100 && since_start != 20; k++) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midreset_state", {busy, done, range_err, aborted, err_count, first_err_addr,
                               bus.avm_chipselect, bus.avm_write, bus.avm_address},
            {4'b0, 13'd0, 12'd0, 2'b0, 12'd0});
      check("midreset_data", {bus.avm_byteenable, bus.avm_writedata}, {4'hF, 32'd0});
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("midreset_no_done", 64'(done_cnt), 64'(d0));
      check("midreset_writes_seen", 64'(wr_q.size()), 64'd0);

      run_op(12'h020, 13'd4, 32'h12345678, 1'b0, 1'b0, 4, 0, 5, 1'b0, 1'b0, 13'd0, 12'h000, -1, "after_reset");
      check("done_q_empty", 64'(done_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
